// File: rtl/count_connected_batch_feeder.sv
// Batch feeder for a connected-component counting core: issues tagged bots, sums 2^connectCount of results.
// Optional FEEDER_ECC_ABORT_EN: an ECC strobe from the core aborts the running batch instead of only flagging it.
module count_connected_batch_feeder #(
    parameter int TAG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [15:0]          batchSize,
    input  logic                 srcValid,
    input  logic [127:0]         srcGraph,
    output logic                 srcReady,
    output logic                 isBotValid,
    output logic [127:0]         graphIn,
    output logic [TAG_WIDTH-1:0] extraDataIn,
    input  logic                 slowDownInput,
    input  logic                 resultValid,
    input  logic [5:0]           connectCount,
    input  logic [TAG_WIDTH-1:0] extraDataOut,
    input  logic                 eccStatus,
    output logic                 busy,
    output logic                 done,
    output logic [79:0]          sumOut,
    output logic                 orderError,
    output logic                 eccError,
    output logic                 strayResult
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] batch_r;
    logic [15:0] issued_r;
    logic [15:0] received_r;

    logic        active_s;
    logic        accept_s;
    logic        count_s;
    logic        tag_bad_s;
    logic        finish_s;
    logic        ecc_abort_s;
    logic [15:0] issued_n_s;
    logic [15:0] received_n_s;

    function automatic logic [79:0] pow2(input logic [5:0] e);
        pow2 = 80'd1 << e;
    endfunction

    // Acceptance, result qualification and next counter values.
    always_comb begin
        active_s     = (state_r == FEED) || (state_r == DRAIN);
        srcReady     = (state_r == FEED) && !slowDownInput && (issued_r < batch_r);
        accept_s     = srcValid && srcReady;
        // A result with nothing outstanding is a protocol error and is never counted.
        count_s      = active_s && resultValid && (received_r != issued_r);
        tag_bad_s    = active_s && resultValid &&
                       ((received_r == issued_r) || (extraDataOut != received_r[TAG_WIDTH-1:0]));
        issued_n_s   = issued_r + {15'd0, accept_s};
        received_n_s = received_r + {15'd0, count_s};
        finish_s     = active_s && (issued_n_s == batch_r) && (received_n_s == batch_r);
`ifdef FEEDER_ECC_ABORT_EN
        ecc_abort_s  = active_s && eccStatus;
`else
        ecc_abort_s  = 1'b0;
`endif
    end

    // Batch FSM with all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            batch_r     <= 16'd0;
            issued_r    <= 16'd0;
            received_r  <= 16'd0;
            isBotValid  <= 1'b0;
            graphIn     <= 128'd0;
            extraDataIn <= {TAG_WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            sumOut      <= 80'd0;
            orderError  <= 1'b0;
            eccError    <= 1'b0;
            strayResult <= 1'b0;
        end else begin
            done       <= 1'b0;
            isBotValid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (resultValid) begin
                        strayResult <= 1'b1;
                    end
                    if (start) begin
                        batch_r    <= batchSize;
                        issued_r   <= 16'd0;
                        received_r <= 16'd0;
                        sumOut     <= 80'd0;
                        orderError <= 1'b0;
                        eccError   <= 1'b0;
                        if (batchSize == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state_r <= FEED;
                            busy    <= 1'b1;
                        end
                    end
                end
                FEED, DRAIN: begin
                    if (accept_s) begin
                        isBotValid  <= 1'b1;
                        graphIn     <= srcGraph;
                        extraDataIn <= issued_r[TAG_WIDTH-1:0];
                    end
                    issued_r   <= issued_n_s;
                    received_r <= received_n_s;
                    if (count_s) begin
                        sumOut <= sumOut + pow2(connectCount);
                    end
                    if (tag_bad_s) begin
                        orderError <= 1'b1;
                    end
                    if (eccStatus) begin
                        eccError <= 1'b1;
                    end
                    // Completion is decided on next-cycle counts so done follows the last result directly.
                    if (finish_s || ecc_abort_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (issued_n_s == batch_r) begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_connected_batch_feeder.sv
// Self-checking bench: the bench plays the counting core and compares the feeder against a batch-level model.
module tb_count_connected_batch_feeder;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [15:0]  batchSize;
    logic         srcValid;
    logic [127:0] srcGraph;
    logic         srcReady;
    logic         isBotValid;
    logic [127:0] graphIn;
    logic [15:0]  extraDataIn;
    logic         slowDownInput;
    logic         resultValid;
    logic [5:0]   connectCount;
    logic [15:0]  extraDataOut;
    logic         eccStatus;
    logic         busy;
    logic         done;
    logic [79:0]  sumOut;
    logic         orderError;
    logic         eccError;
    logic         strayResult;

    count_connected_batch_feeder #(.TAG_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .batchSize(batchSize),
        .srcValid(srcValid), .srcGraph(srcGraph), .srcReady(srcReady),
        .isBotValid(isBotValid), .graphIn(graphIn), .extraDataIn(extraDataIn),
        .slowDownInput(slowDownInput), .resultValid(resultValid),
        .connectCount(connectCount), .extraDataOut(extraDataOut),
        .eccStatus(eccStatus), .busy(busy), .done(done), .sumOut(sumOut),
        .orderError(orderError), .eccError(eccError), .strayResult(strayResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: batch-level bookkeeping
    bit           active_m;
    int           batch_m, issued_m, received_m;
    logic [79:0]  sum_m;
    bit           order_m, ecc_m, stray_m;
    bit           exp_bv, exp_done;
    logic [127:0] exp_graph;
    logic [15:0]  exp_tag;
    logic [15:0]  inflight[$];

    // Scenario knobs
    int  k_valid = 100, k_res = 100, k_slow_pct = 0, k_rs = 0;
    bit  k_slow = 1'b0, k_start = 1'b0, k_ecc = 1'b0, k_force = 1'b0;
    int  k_bs = 0, k_corrupt = -1, k_cc_fix = -1;
    int  k_cc_q[$];
    int  dut_bv_cnt, dut_done_cnt;

    function automatic bit pct(input int p);
        pct = ($urandom_range(99, 0) < p);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_srcReady"}, srcReady, 1'b0);
        check({tag, "_isBotValid"}, isBotValid, 1'b0);
        check({tag, "_graphIn"}, graphIn, 128'd0);
        check({tag, "_extraDataIn"}, extraDataIn, 16'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_sumOut"}, sumOut, 80'd0);
        check({tag, "_orderError"}, orderError, 1'b0);
        check({tag, "_eccError"}, eccError, 1'b0);
        check({tag, "_strayResult"}, strayResult, 1'b0);
    endtask

    task automatic model_reset();
        active_m = 1'b0; batch_m = 0; issued_m = 0; received_m = 0;
        sum_m = 80'd0; order_m = 1'b0; ecc_m = 1'b0; stray_m = 1'b0;
        exp_bv = 1'b0; exp_done = 1'b0;
    endtask

    // One clock: check outputs, drive next inputs as the core/source, advance the model.
    task automatic cycle();
        bit          was_active, acc, rv, exp_ready;
        int          cc;
        logic [15:0] rtag;
        @(posedge clk);
        #1;
        check("isBotValid", isBotValid, exp_bv);
        if (exp_bv) begin
            check("graphIn", graphIn, exp_graph);
            check("extraDataIn", extraDataIn, exp_tag);
            inflight.push_back(exp_tag);
        end
        check("done", done, exp_done);
        check("busy", busy, active_m);
        check("sumOut", sumOut, sum_m);
        check("orderError", orderError, order_m);
        check("eccError", eccError, ecc_m);
        check("strayResult", strayResult, stray_m);
        dut_bv_cnt += int'(isBotValid);
        dut_done_cnt += int'(done);

        start = k_start || (active_m && pct(k_rs));
        batchSize = k_start ? 16'(k_bs) : 16'($urandom_range(20, 0));
        k_start = 1'b0;
        srcValid = pct(k_valid);
        srcGraph = {$urandom(), $urandom(), $urandom(), $urandom()};
        slowDownInput = k_slow || pct(k_slow_pct);
        rv = 1'b0;
        rtag = 16'd0;
        cc = int'($urandom_range(63, 0));
        if (k_force) begin
            rv = 1'b1;
            k_force = 1'b0;
        end else if (inflight.size() > 0 && pct(k_res)) begin
            rv = 1'b1;
            rtag = inflight.pop_front();
            if (k_corrupt >= 0 && int'(rtag) == k_corrupt) rtag = rtag + 16'd1;
            if (k_cc_q.size() > 0) cc = k_cc_q.pop_front();
            else if (k_cc_fix >= 0) cc = k_cc_fix;
        end
        resultValid = rv;
        connectCount = 6'(cc);
        extraDataOut = rtag;
        eccStatus = k_ecc;
        k_ecc = 1'b0;
        #1;
        exp_ready = active_m && !slowDownInput && (issued_m < batch_m);
        check("srcReady", srcReady, exp_ready);

        was_active = active_m;
        acc = srcValid && exp_ready;
        exp_done = 1'b0;
        if (rv) begin
            if (!was_active) stray_m = 1'b1;
            else if (received_m == issued_m) order_m = 1'b1;
            else begin
                sum_m = sum_m + (80'd1 << cc);
                if (rtag != 16'(received_m)) order_m = 1'b1;
                received_m++;
            end
        end
        exp_bv = acc;
        if (acc) begin
            exp_graph = srcGraph;
            exp_tag = 16'(issued_m);
            issued_m++;
        end
        if (was_active && eccStatus) begin
            ecc_m = 1'b1;
`ifdef FEEDER_ECC_ABORT_EN
            active_m = 1'b0;
            exp_done = 1'b1;
`endif
        end
        if (was_active && active_m && issued_m == batch_m && received_m == batch_m) begin
            active_m = 1'b0;
            exp_done = 1'b1;
        end
        if (!was_active && start) begin
            batch_m = int'(batchSize); issued_m = 0; received_m = 0;
            sum_m = 80'd0; order_m = 1'b0; ecc_m = 1'b0;
            if (batchSize == 16'd0) exp_done = 1'b1;
            else active_m = 1'b1;
        end
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        while (active_m && n < maxc) begin
            cycle();
            n++;
        end
        checks++;
        assert (!active_m) else begin
            errors++;
            $error("FAIL timeout batch still active after %0d cycles, expected idle", n);
        end
        cycle();
    endtask

    task automatic run_batch(input int bs);
        dut_bv_cnt = 0;
        dut_done_cnt = 0;
        k_start = 1'b1;
        k_bs = bs;
        cycle();
        run_until_idle(2000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [79:0] big_sum;

    initial begin
        rstn = 1'b0; start = 1'b0; batchSize = 16'd0; srcValid = 1'b0; srcGraph = 128'd0;
        slowDownInput = 1'b0; resultValid = 1'b0; connectCount = 6'd0;
        extraDataOut = 16'd0; eccStatus = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Four bots, results 1,2,3,0 in order
        k_cc_q = {1, 2, 3, 0};
        run_batch(4);
        check("s1_sum", sumOut, 80'd15);
        check("s1_bv_count", 128'(dut_bv_cnt), 128'd4);
        check("s1_done_count", 128'(dut_done_cnt), 128'd1);

        // Ten cycles of backpressure mid-feed
        dut_bv_cnt = 0;
        k_res = 50;
        k_start = 1'b1; k_bs = 20;
        cycle();
        idle(4);
        k_slow = 1'b1;
        idle(10);
        k_slow = 1'b0;
        run_until_idle(2000);
        check("s2_bv_count", 128'(dut_bv_cnt), 128'd20);
        k_res = 100;

        // Second result returns the wrong tag
        k_corrupt = 1;
        run_batch(2);
        check("s3_orderError", orderError, 1'b1);
        k_corrupt = -1;

        // Maximum exponent, no truncation
        k_cc_fix = 63;
        run_batch(3);
        big_sum = 80'd3 << 63;
        check("s4_sum", sumOut, big_sum);
        k_cc_fix = -1;

        // ECC strobe while draining
        k_res = 0;
        k_start = 1'b1; k_bs = 4;
        cycle();
        for (int i = 0; i < 20 && issued_m < batch_m; i++) cycle();
        cycle();
        k_ecc = 1'b1;
        cycle();
        k_res = 100;
        run_until_idle(2000);
        check("s5_eccError", eccError, 1'b1);
        idle(8);

        // Empty batch
        run_batch(0);
        check("s6_sum_zero", sumOut, 80'd0);

        // Result with nothing outstanding
        k_valid = 0;
        k_start = 1'b1; k_bs = 2;
        cycle();
        k_force = 1'b1;
        cycle();
        k_valid = 100;
        run_until_idle(2000);
        check("s7_orderError", orderError, 1'b1);

        // Randomised batches with ignored mid-batch starts
        k_rs = 10;
        for (int b = 0; b < 8; b++) begin
            k_valid = int'($urandom_range(100, 30));
            k_res = int'($urandom_range(100, 30));
            k_slow_pct = int'($urandom_range(40, 0));
            run_batch(int'($urandom_range(12, 1)));
            idle(2);
        end
        k_rs = 0; k_slow_pct = 0; k_valid = 100;

        // Reset mid-feed, then late results from the core
        k_res = 0;
        k_start = 1'b1; k_bs = 10;
        cycle();
        idle(5);
        #1;
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        start = 1'b0; srcValid = 1'b0; resultValid = 1'b0; eccStatus = 1'b0; slowDownInput = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        k_res = 100;
        idle(8);
        check("s9_strayResult", strayResult, 1'b1);
        check("s9_sum", sumOut, 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
